// File: rtl/fetch_respond_ooo_if.sv
// ----------------------------------------------------------------------------
// fetch_respond_ooo_if
//   Bundles every handshake and bus signal between fetch issue/receive, the
//   responder, and the tagged out-of-order backing memory.
//
//   slave  modport : the responder (fetch_respond_ooo)
//   master modport : the surrounding fetch pipeline / memory / testbench
//
//   Signals
//     req_valid/req_ready/req_PC           fetch issue -> responder
//     mem_req_valid/ready/addr/tag         responder -> memory read request
//     mem_resp_valid/tag/data              memory -> responder (no backpressure)
//     resp_valid/ready/instruction/PC      responder -> fetch receive
//     outstanding                          count of non-FREE entries
//     flush                                discard every outstanding fetch
// ----------------------------------------------------------------------------
interface fetch_respond_ooo_if #(
    parameter int XLEN      = 64,
    parameter int TAG_WIDTH = 3
);
    logic                 req_valid;
    logic                 req_ready;
    logic [XLEN-1:0]      req_PC;

    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [XLEN-1:0]      mem_req_addr;
    logic [TAG_WIDTH-1:0] mem_req_tag;

    logic                 mem_resp_valid;
    logic [TAG_WIDTH-1:0] mem_resp_tag;
    logic [63:0]          mem_resp_data;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [63:0]          resp_instruction;
    logic [XLEN-1:0]      resp_PC;

    logic [TAG_WIDTH:0]   outstanding;
    logic                 flush;

    modport slave (
        input  req_valid, req_PC, mem_req_ready,
               mem_resp_valid, mem_resp_tag, mem_resp_data,
               resp_ready, flush,
        output req_ready, mem_req_valid, mem_req_addr, mem_req_tag,
               resp_valid, resp_instruction, resp_PC, outstanding
    );

    modport master (
        output req_valid, req_PC, mem_req_ready,
               mem_resp_valid, mem_resp_tag, mem_resp_data,
               resp_ready, flush,
        input  req_ready, mem_req_valid, mem_req_addr, mem_req_tag,
               resp_valid, resp_instruction, resp_PC, outstanding
    );
endinterface

// File: rtl/fetch_respond_ooo.sv
// ----------------------------------------------------------------------------
// fetch_respond_ooo
//   I-cache-side responder. Accepts fetch PCs into a pool of 2**TAG_WIDTH
//   entries, issues doubleword-aligned reads to a tagged out-of-order memory
//   (tag = entry index), and hands {doubleword, original PC} to the fetch
//   receive stage through a one-entry output register as responses complete.
//
//   Ports
//     clock  : system clock
//     reset  : asynchronous, active-low reset
//     bus    : fetch_respond_ooo_if.slave (request, memory, response, flush)
//
//   Entry life cycle
//     FREE -> PEND (accepted) -> WAIT (issued) -> READY (data back) -> FREE
//     A flush frees PEND/READY entries at once, but a WAIT entry becomes SQUASH
//     and keeps its tag until memory answers, so a stale response can never be
//     matched to a newer fetch that reused the tag.
// ----------------------------------------------------------------------------
module fetch_respond_ooo #(
    parameter int XLEN      = 64,
    parameter int TAG_WIDTH = 3
) (
    input  logic                clock,
    input  logic                reset,
    fetch_respond_ooo_if.slave  bus
);
    localparam int SLOTS = 1 << TAG_WIDTH;

    typedef enum logic [2:0] {FREE, PEND, WAIT, READY, SQUASH} entry_state_t;

    entry_state_t         state    [SLOTS];
    logic [XLEN-1:0]      pc_mem   [SLOTS];
    logic [63:0]          data_mem [SLOTS];

    logic                 out_valid;
    logic [63:0]          out_data;
    logic [XLEN-1:0]      out_pc;

    logic                 free_any, pend_any, ready_any;
    logic [TAG_WIDTH-1:0] free_idx, pend_idx, ready_idx;
    logic [TAG_WIDTH:0]   busy_cnt;

    logic                 req_ready_i, mem_req_valid_i;
    logic                 accept, issue, drain, load, capture;

    // Lowest-index search per state, plus the busy count. Walking from the top
    // down lets the last hit (the lowest index) win.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        free_any  = 1'b0;
        pend_any  = 1'b0;
        ready_any = 1'b0;
        free_idx  = '0;
        pend_idx  = '0;
        ready_idx = '0;
        busy_cnt  = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (state[i] == FREE) begin
                free_any = 1'b1;
                free_idx = TAG_WIDTH'(i);
            end else begin
                busy_cnt = busy_cnt + (TAG_WIDTH + 1)'(1);
            end
            if (state[i] == PEND) begin
                pend_any = 1'b1;
                pend_idx = TAG_WIDTH'(i);
            end
            if (state[i] == READY) begin
                ready_any = 1'b1;
                ready_idx = TAG_WIDTH'(i);
            end
        end
    end

    // reset gates req_ready because every entry reads FREE while reset is held.
    assign req_ready_i     = reset & free_any & ~bus.flush;
    assign mem_req_valid_i = pend_any & ~bus.flush;

    assign accept  = bus.req_valid & req_ready_i;
    assign issue   = mem_req_valid_i & bus.mem_req_ready;
    assign drain   = out_valid & bus.resp_ready;
    // The output register refills whenever it is empty or emptying this cycle.
    assign load    = ready_any & (~out_valid | bus.resp_ready);
    assign capture = bus.mem_resp_valid & ~bus.flush & (state[bus.mem_resp_tag] == WAIT);

    assign bus.req_ready        = req_ready_i;
    assign bus.mem_req_valid    = mem_req_valid_i;
    assign bus.mem_req_tag      = pend_idx;
    assign bus.mem_req_addr     = pend_any ? {pc_mem[pend_idx][XLEN-1:3], 3'b000} : '0;
    assign bus.resp_valid       = out_valid;
    assign bus.resp_instruction = out_data;
    assign bus.resp_PC          = out_pc;
    assign bus.outstanding      = busy_cnt;

    // Entry states and output register. Accept, issue, response and load each
    // act on an entry in a different state, so they never collide on one index.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (!reset) begin
            for (int i = 0; i < SLOTS; i++) state[i] <= FREE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_pc    <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < SLOTS; i++) begin
                case (state[i])
                    PEND, READY: state[i] <= FREE;
                    WAIT:        state[i] <= SQUASH;
                    default:     ;
                endcase
            end
            // A response arriving in the flush cycle retires its tag outright.
            if (bus.mem_resp_valid &&
                (state[bus.mem_resp_tag] == WAIT || state[bus.mem_resp_tag] == SQUASH))
                state[bus.mem_resp_tag] <= FREE;
            out_valid <= 1'b0;
        end else begin
            if (accept) state[free_idx] <= PEND;
            if (issue)  state[pend_idx] <= WAIT;
            if (bus.mem_resp_valid) begin
                case (state[bus.mem_resp_tag])
                    WAIT:    state[bus.mem_resp_tag] <= READY;
                    SQUASH:  state[bus.mem_resp_tag] <= FREE;
                    default: ;
                endcase
            end
            if (load) begin
                state[ready_idx] <= FREE;
                out_valid        <= 1'b1;
                out_data         <= data_mem[ready_idx];
                out_pc           <= pc_mem[ready_idx];
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Payload storage is only read from entries whose state says it was written.
    // NOTE: these arrays are deliberately not reset; validity lives in state[],
    // and leaving storage out of reset keeps it as plain memory.
    always_ff @(posedge clock) begin
        if (accept)  pc_mem[free_idx]            <= bus.req_PC;
        if (capture) data_mem[bus.mem_resp_tag] <= bus.mem_resp_data;
    end
endmodule

// File: tb/tb_fetch_respond_ooo.sv
// ----------------------------------------------------------------------------
// tb_fetch_respond_ooo
//   Directed bench for fetch_respond_ooo. A set-based reference model (one bit
//   mask per life-cycle phase) predicts every output each cycle; directed
//   literal expectations pin the scenarios described for the block.
// ----------------------------------------------------------------------------
module tb_fetch_respond_ooo;
    localparam int XLEN  = 64;
    localparam int TW    = 3;
    localparam int SLOTS = 1 << TW;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fetch_respond_ooo_if #(.XLEN(XLEN), .TAG_WIDTH(TW)) bus ();

    fetch_respond_ooo #(.XLEN(XLEN), .TAG_WIDTH(TW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] got_pc [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each fetch slot sits in exactly one mask: waiting to be sent, at memory,
    // data back, or dropped-but-still-at-memory. Output register kept apart.
    logic [SLOTS-1:0] m_pend = '0, m_mem = '0, m_done = '0, m_drop = '0;
    logic [63:0]      m_pc  [SLOTS];
    logic [63:0]      m_dat [SLOTS];
    logic             m_ov = 1'b0;
    logic [63:0]      m_opc = '0, m_odat = '0;

    function automatic int lowest(input logic [SLOTS-1:0] m);
        for (int i = 0; i < SLOTS; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic logic [SLOTS-1:0] m_busy();
        return m_pend | m_mem | m_done | m_drop;
    endfunction

    function automatic logic exp_req_ready();
        return reset && (m_busy() != '1) && !bus.flush;
    endfunction

    function automatic logic exp_mem_valid();
        return reset && (m_pend != '0) && !bus.flush;
    endfunction

    task automatic model_step();
        logic [SLOTS-1:0] mem0, done0, drop0;
        int a, p, r, t;
        logic acc, iss, ld, drn;
        if (!reset) begin
            m_pend = '0; m_mem = '0; m_done = '0; m_drop = '0; m_ov = 1'b0;
            return;
        end
        mem0 = m_mem; done0 = m_done; drop0 = m_drop;
        t = int'(bus.mem_resp_tag);
        if (bus.flush) begin
            m_drop = drop0 | mem0;
            if (bus.mem_resp_valid) m_drop[t] = 1'b0;
            m_pend = '0; m_mem = '0; m_done = '0; m_ov = 1'b0;
            return;
        end
        acc = bus.req_valid && exp_req_ready();
        a   = lowest(~m_busy());
        iss = exp_mem_valid() && bus.mem_req_ready;
        p   = lowest(m_pend);
        drn = m_ov && bus.resp_ready;
        ld  = (done0 != '0) && (!m_ov || bus.resp_ready);
        r   = lowest(done0);
        if (iss) begin m_pend[p] = 1'b0; m_mem[p] = 1'b1; end
        if (acc) begin m_pend[a] = 1'b1; m_pc[a] = bus.req_PC; end
        if (bus.mem_resp_valid) begin
            if (mem0[t]) begin
                m_mem[t] = 1'b0; m_done[t] = 1'b1; m_dat[t] = bus.mem_resp_data;
            end else if (drop0[t]) begin
                m_drop[t] = 1'b0;
            end
        end
        if (ld) begin
            m_done[r] = 1'b0; m_opc = m_pc[r]; m_odat = m_dat[r]; m_ov = 1'b1;
        end else if (drn) begin
            m_ov = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clock or negedge reset);
        model_step();
    end

    // ---------------- per-cycle compare (mid-cycle) ----------------
    initial forever begin
        int p;
        @(negedge clock);
        check("req_ready", 64'(bus.req_ready), 64'(exp_req_ready()));
        check("mem_req_valid", 64'(bus.mem_req_valid), 64'(exp_mem_valid()));
        if (exp_mem_valid()) begin
            p = lowest(m_pend);
            check("mem_req_tag", 64'(bus.mem_req_tag), 64'(p));
            check("mem_req_addr", bus.mem_req_addr, {m_pc[p][63:3], 3'b000});
        end
        check("resp_valid", 64'(bus.resp_valid), 64'(m_ov));
        if (m_ov) begin
            check("resp_PC", bus.resp_PC, m_opc);
            check("resp_instruction", bus.resp_instruction, m_odat);
        end
        check("outstanding", 64'(bus.outstanding), 64'($countones(m_busy())));
        if (reset && bus.resp_valid && bus.resp_ready && !bus.flush)
            got_pc.push_back(bus.resp_PC);
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.req_valid      = 1'b0;
        bus.req_PC         = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_tag   = '0;
        bus.mem_resp_data  = '0;
        bus.resp_ready     = 1'b1;
        bus.flush          = 1'b0;
    endtask

    task automatic send(input logic [63:0] pc);
        bus.req_valid = 1'b1;
        bus.req_PC    = pc;
        cyc();
        bus.req_valid = 1'b0;
    endtask

    task automatic mem_resp(input int tag, input logic [63:0] data);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_tag   = TW'(tag);
        bus.mem_resp_data  = data;
        cyc();
        bus.mem_resp_valid = 1'b0;
    endtask

    // Flush, then answer every tag so any squashed entries retire.
    task automatic drain_all(input string name);
        idle();
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        for (int t = 0; t < SLOTS; t++) mem_resp(t, 64'hDEAD_0000 + 64'(t));
        #1;
        check(name, 64'(bus.outstanding), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int k;
        idle();
        #1 reset = 1'b0;
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_outstanding", 64'(bus.outstanding), 64'd0);
        repeat (2) cyc();
        reset = 1'b1;
        #1;
        check("post_rst_req_ready", 64'(bus.req_ready), 64'd1);

        // 1: single fetch, minimum latencies
        bus.req_valid = 1'b1;
        bus.req_PC    = 64'h1004;
        #1 check("t1_req_ready", 64'(bus.req_ready), 64'd1);
        cyc();
        bus.req_valid = 1'b0;
        #1;
        check("t1_mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
        check("t1_mem_req_addr", bus.mem_req_addr, 64'h1000);
        check("t1_mem_req_tag", 64'(bus.mem_req_tag), 64'd0);
        bus.mem_req_ready = 1'b1;
        cyc();
        bus.mem_req_ready = 1'b0;
        mem_resp(0, 64'hAAAA_BBBB_CCCC_DDDD);
        check("t1_resp_not_yet", 64'(bus.resp_valid), 64'd0);
        cyc();
        check("t1_resp_valid", 64'(bus.resp_valid), 64'd1);
        check("t1_resp_PC", bus.resp_PC, 64'h1004);
        check("t1_resp_data", bus.resp_instruction, 64'hAAAA_BBBB_CCCC_DDDD);
        check("t1_outstanding", 64'(bus.outstanding), 64'd0);
        cyc();
        check("t1_drained", 64'(bus.resp_valid), 64'd0);

        // 2: out-of-order completion order
        bus.mem_req_ready = 1'b1;
        send(64'h100);
        send(64'h108);
        send(64'h110);
        cyc();
        bus.mem_req_ready = 1'b0;
        got_pc.delete();
        mem_resp(2, 64'h2222);
        mem_resp(0, 64'h0000);
        mem_resp(1, 64'h1111);
        k = 0;
        while (got_pc.size() < 3 && k < 10) begin cyc(); k++; end
        check("t2_count", 64'(got_pc.size()), 64'd3);
        if (got_pc.size() == 3) begin
            check("t2_first", got_pc[0], 64'h110);
            check("t2_second", got_pc[1], 64'h100);
            check("t2_third", got_pc[2], 64'h108);
        end

        // 3: full pool, free one, reuse its tag
        for (int i = 0; i < SLOTS; i++) send(64'h2000 + 64'(8 * i));
        #1;
        check("t3_full_ready", 64'(bus.req_ready), 64'd0);
        check("t3_full_count", 64'(bus.outstanding), 64'd8);
        bus.mem_req_ready = 1'b1;
        cyc();
        cyc();
        bus.mem_req_ready = 1'b0;
        mem_resp(1, 64'h0123_4567_89AB_CDEF);
        check("t3_ready_still_0", 64'(bus.req_ready), 64'd0);
        cyc();
        check("t3_ready_after_free", 64'(bus.req_ready), 64'd1);
        send(64'h3000);
        #1;
        check("t3_reuse_tag", 64'(bus.mem_req_tag), 64'd1);
        check("t3_reuse_addr", bus.mem_req_addr, 64'h3000);
        check("t3_count", 64'(bus.outstanding), 64'd8);
        drain_all("t3_cleanup");

        // 4: receiver backpressure
        bus.resp_ready    = 1'b0;
        bus.mem_req_ready = 1'b1;
        send(64'h400);
        send(64'h40C);
        cyc();
        bus.mem_req_ready = 1'b0;
        mem_resp(0, 64'h4444_0000_4444_0000);
        mem_resp(1, 64'h5555_1111_5555_1111);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 64'(bus.resp_valid), 64'd1);
            check("t4_hold_PC", bus.resp_PC, 64'h400);
            check("t4_hold_data", bus.resp_instruction, 64'h4444_0000_4444_0000);
            cyc();
        end
        bus.resp_ready = 1'b1;
        cyc();
        check("t4_next_valid", 64'(bus.resp_valid), 64'd1);
        check("t4_next_PC", bus.resp_PC, 64'h40C);
        check("t4_next_data", bus.resp_instruction, 64'h5555_1111_5555_1111);
        cyc();
        check("t4_empty", 64'(bus.resp_valid), 64'd0);

        // 5: flush with READY / WAIT / PEND entries, then a late response
        bus.mem_req_ready = 1'b1;
        send(64'h500);
        send(64'h508);
        send(64'h510);
        bus.mem_req_ready = 1'b0;
        mem_resp(0, 64'h5000);
        bus.flush = 1'b1;
        #1;
        check("t5_flush_req_ready", 64'(bus.req_ready), 64'd0);
        check("t5_flush_mem_valid", 64'(bus.mem_req_valid), 64'd0);
        check("t5_pre_flush_count", 64'(bus.outstanding), 64'd3);
        cyc();
        bus.flush = 1'b0;
        #1;
        check("t5_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("t5_count", 64'(bus.outstanding), 64'd1);
        for (int i = 0; i < SLOTS - 1; i++) send(64'h600 + 64'(8 * i));
        #1;
        check("t5_tag1_held", 64'(bus.req_ready), 64'd0);
        check("t5_full_count", 64'(bus.outstanding), 64'd8);
        mem_resp(1, 64'hBAD1);
        check("t5_late_count", 64'(bus.outstanding), 64'd7);
        check("t5_late_ready", 64'(bus.req_ready), 64'd1);
        cyc();
        check("t5_no_resp", 64'(bus.resp_valid), 64'd0);
        drain_all("t5_cleanup");

        // 5b: response arriving in the flush cycle retires its tag at once
        bus.mem_req_ready = 1'b1;
        send(64'h800);
        cyc();
        bus.mem_req_ready  = 1'b0;
        bus.flush          = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_tag   = '0;
        bus.mem_resp_data  = 64'h8888;
        cyc();
        bus.flush          = 1'b0;
        bus.mem_resp_valid = 1'b0;
        #1;
        check("t5b_count", 64'(bus.outstanding), 64'd0);
        check("t5b_no_resp", 64'(bus.resp_valid), 64'd0);

        // 6: asynchronous reset mid-operation
        for (int i = 0; i < 4; i++) send(64'h900 + 64'(8 * i));
        #1;
        check("t6_busy", 64'(bus.outstanding), 64'd4);
        reset = 1'b0;
        #1;
        check("t6_rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("t6_rst_mem_valid", 64'(bus.mem_req_valid), 64'd0);
        check("t6_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("t6_rst_count", 64'(bus.outstanding), 64'd0);
        cyc();
        cyc();
        reset = 1'b1;
        #1;
        check("t6_req_ready", 64'(bus.req_ready), 64'd1);
        check("t6_count", 64'(bus.outstanding), 64'd0);
        bus.mem_req_ready = 1'b1;
        send(64'h700);
        #1;
        check("t6_first_tag", 64'(bus.mem_req_tag), 64'd0);
        check("t6_first_addr", bus.mem_req_addr, 64'h700);
        cyc();
        bus.mem_req_ready = 1'b0;
        mem_resp(0, 64'h7777);
        cyc();
        check("t6_resp_PC", bus.resp_PC, 64'h700);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
